io_slow_out_seq: RTL
====================

Name: io_slow_out_seq

Overview:
- Slow-output character sequencer for the typewriter/punch path.
- Per character, samples a 3-bit format code at word start T0, shifts a 4-bit digit serially out of the MZ/M19 output line, and encodes a 6-bit device character.
- Hands the character to the output device with a valid/ack handshake.
- Generates the format-decode flags DIGIT_OF, WAIT_OF and CR_TAB_OF, and the RELOAD request consumed by the I/O 11 / MZ logic.

Parameters:
- DIGIT_BITS, 4, serial bits shifted per character.
- TIMEOUT_WORDS, 1024, word times allowed for DEV_ACK; used only when the optional feature is compiled in.

Ports:
- CLOCK  input  1  system bit clock.
- rst_n  input  1  reset; asynchronous, active-low.
- T0  input  1  word-start pulse, one clock per word time.
- START  input  1  slow-out command; one-clock pulse.
- STOP  input  1  abort; level.
- FMT  input  3  format code; valid in the T0 cycle.
- DIN  input  1  serial digit bit from the output line, LSB first.
- DEV_ACK  input  1  device accepted CHAR.
- SHIFT_EN  output  1  shift request to the output line.
- CHAR  output  6  encoded character.
- CHAR_VALID  output  1  CHAR presented.
- DIGIT_OF, WAIT_OF, CR_TAB_OF  output  1 each  format-decode flags.
- RELOAD  output  1  request reload of MZ from M19.
- BUSY  output  1  sequencer active.
- DONE  output  1  one-clock end-of-output pulse.
- TIMEOUT  output  1  device timeout; tied 0 when the feature is compiled out.

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; all outputs 0; digit register 0; bit counter 0.
- Format codes:
  - 000 digit
  - 001 end
  - 010 carriage return
  - 011 period
  - 100 sign
  - 101 reload
  - 110 tab
  - 111 wait
- IDLE: START -> FETCH on the next clock; BUSY=1 from that clock on. START while BUSY is ignored.
- FETCH: wait for T0. In the T0 cycle, latch FMT and set flags, held until the character completes:
  - DIGIT_OF = 000 or 100
  - WAIT_OF = 111
  - CR_TAB_OF = 010 or 110
  - Next state:
    - 000/100/111 -> SHIFT
    - 010/011/110 -> PRESENT
    - 101 -> RELOAD
    - 001 -> END
- SHIFT:
  - SHIFT_EN=1 for exactly DIGIT_BITS consecutive clocks, starting the clock after T0.
  - DIN captured on each of those clocks into digit d[3:0], LSB first.
  - Then: PRESENT, or back to FETCH for WAIT (digit consumed, nothing printed).
- PRESENT: CHAR_VALID=1 with CHAR:
  - digit -> {2'b00, d}
  - sign -> 6'h25 if d[0]=1, else 6'h30
  - CR -> 6'h22
  - period -> 6'h23
  - tab -> 6'h24
- Handshake:
  - CHAR_VALID and CHAR stay stable until DEV_ACK is sampled high.
  - CHAR_VALID drops on the following clock; flags clear; state -> FETCH.
  - DEV_ACK in the first PRESENT cycle is legal.
  - DEV_ACK while CHAR_VALID=0 is ignored.
- RELOAD: RELOAD=1 from the clock after the latching T0 up to and including the next T0; then FETCH. The next format is not sampled on that T0.
- END: DONE=1 for one clock; BUSY=0; state -> IDLE.
- STOP:
  - Any state -> IDLE on the next clock.
  - CHAR_VALID, SHIFT_EN, RELOAD and the flags clear; DONE is not pulsed.
  - STOP has priority over START and DEV_ACK in the same cycle.
- T0 arriving during SHIFT or PRESENT is ignored; the next character waits for the next T0 after returning to FETCH.
- Bit counter width is clog2(DIGIT_BITS+1); it never wraps within a character.

Optional Feature:
- Macro: SLOW_OUT_TIMEOUT_EN.
- With the macro:
  - A word counter counts T0 pulses while CHAR_VALID=1.
  - On reaching TIMEOUT_WORDS: TIMEOUT=1 (sticky), CHAR_VALID drops, state -> IDLE, DONE not pulsed.
  - TIMEOUT clears on the next START or on reset.
  - The counter resets on each new PRESENT entry.
- Without the macro: TIMEOUT constant 0, no counter logic, PRESENT waits indefinitely.

Test Plan:
- Reset and idle: reset, then START; FMT=000 at T0; DIN bits 1,0,1,1 -> SHIFT_EN high 4 clocks after T0, CHAR=6'h0D, CHAR_VALID held until DEV_ACK, DIGIT_OF=1 throughout.
- Sign: FMT=100 with DIN 1,0,0,0 -> CHAR=6'h25. Repeat with DIN all 0 -> CHAR=6'h30.
- Sequence: FMT=111, then 010, then 001 -> WAIT_OF pulse with no CHAR_VALID; then CHAR=6'h22 with CR_TAB_OF=1; then DONE one clock, BUSY=0.
- Reload: FMT=101 -> RELOAD high from T0+1 through the next T0; FMT presented on that T0 is ignored and is sampled on the following T0.
- Abort: STOP asserted mid-SHIFT (after 2 bits) and again during PRESENT with DEV_ACK high the same cycle -> IDLE next clock, all outputs 0, no DONE.
- Timeout (SLOW_OUT_TIMEOUT_EN, TIMEOUT_WORDS=4): withhold DEV_ACK -> TIMEOUT=1 on the 4th T0 after PRESENT entry, BUSY=0; next START clears TIMEOUT.

Source files
------------

// File: rtl/io_slow_out_seq.sv
// io_slow_out_seq: slow-output character sequencer (format decode, serial digit, device handshake); device timeout compiled in with SLOW_OUT_TIMEOUT_EN
module io_slow_out_seq #(
  parameter int DIGIT_BITS    = 4,
  parameter int TIMEOUT_WORDS = 1024
) (
  input  logic       CLOCK,
  input  logic       rst_n,
  input  logic       T0,
  input  logic       START,
  input  logic       STOP,
  input  logic [2:0] FMT,
  input  logic       DIN,
  input  logic       DEV_ACK,
  output logic       SHIFT_EN,
  output logic [5:0] CHAR,
  output logic       CHAR_VALID,
  output logic       DIGIT_OF,
  output logic       WAIT_OF,
  output logic       CR_TAB_OF,
  output logic       RELOAD,
  output logic       BUSY,
  output logic       DONE,
  output logic       TIMEOUT
);
  localparam int CW = $clog2(DIGIT_BITS + 1);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SHIFT, S_PRESENT, S_RELOAD, S_END} state_t;
  state_t                r_state;
  state_t                w_next;
  logic [2:0]            r_fmt;
  logic [DIGIT_BITS-1:0] r_digit;
  logic [CW-1:0]         r_cnt;
  logic                  r_digit_of;
  logic                  r_wait_of;
  logic                  r_cr_tab_of;
  logic                  w_last;
  logic                  w_load;
  logic                  w_keep;
  logic                  w_tmo;

  if (DIGIT_BITS < 2 || DIGIT_BITS > 6 || TIMEOUT_WORDS < 1) begin : g_param_check
    $error("io_slow_out_seq: unsupported DIGIT_BITS or TIMEOUT_WORDS");
  end

  assign w_last = r_cnt == CW'(DIGIT_BITS - 1);
  assign w_load = r_state == S_FETCH && T0 && !STOP;
  assign w_keep = w_next != S_IDLE && w_next != S_FETCH;

`ifdef SLOW_OUT_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_WORDS + 1);
  logic [WW-1:0] r_words;
  logic          r_timeout;
  assign w_tmo   = r_state == S_PRESENT && T0 && !DEV_ACK && !STOP && r_words == WW'(TIMEOUT_WORDS - 1);
  assign TIMEOUT = r_timeout;
  // word counter restarts on every PRESENT entry; timeout stays set until the next accepted START
  always_ff @(posedge CLOCK or negedge rst_n)
    if (!rst_n) begin
      r_words   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_words   <= r_state == S_PRESENT ? r_words + WW'(T0) : '0;
      r_timeout <= w_tmo | (r_timeout & ~(r_state == S_IDLE && START && !STOP));
    end
`else
  assign w_tmo   = 1'b0;
  assign TIMEOUT = 1'b0;
`endif

  // state register, latched format, decode flags, LSB-first digit shifter and bit counter
  always_ff @(posedge CLOCK or negedge rst_n)
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_fmt       <= '0;
      r_digit     <= '0;
      r_cnt       <= '0;
      r_digit_of  <= 1'b0;
      r_wait_of   <= 1'b0;
      r_cr_tab_of <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_fmt       <= w_load ? FMT : r_fmt;
      r_digit     <= r_state == S_SHIFT ? {DIN, r_digit[DIGIT_BITS-1:1]} : r_digit;
      r_cnt       <= (r_state == S_SHIFT && w_next == S_SHIFT) ? r_cnt + CW'(1) : '0;
      r_digit_of  <= w_load ? FMT[1:0] == 2'b00 : w_keep & r_digit_of;
      r_wait_of   <= w_load ? FMT == 3'b111 : w_keep & r_wait_of;
      r_cr_tab_of <= w_load ? FMT[1:0] == 2'b10 : w_keep & r_cr_tab_of;
    end

  // next state (STOP overrides everything) and state-decoded outputs
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (START) w_next = S_FETCH;
      S_FETCH:   if (T0) w_next = FMT == 3'b001 ? S_END : FMT == 3'b101 ? S_RELOAD :
                                  (FMT[1:0] == 2'b00 || FMT == 3'b111) ? S_SHIFT : S_PRESENT;
      S_SHIFT:   if (w_last) w_next = r_wait_of ? S_FETCH : S_PRESENT;
      S_PRESENT: w_next = DEV_ACK ? S_FETCH : w_tmo ? S_IDLE : S_PRESENT;
      S_RELOAD:  if (T0) w_next = S_FETCH;
      S_END:     w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    if (STOP) w_next = S_IDLE;
    SHIFT_EN   = r_state == S_SHIFT;
    CHAR_VALID = r_state == S_PRESENT;
    RELOAD     = r_state == S_RELOAD;
    DONE       = r_state == S_END;
    BUSY       = r_state != S_IDLE && r_state != S_END;
    DIGIT_OF   = r_digit_of;
    WAIT_OF    = r_wait_of;
    CR_TAB_OF  = r_cr_tab_of;
    CHAR       = r_state != S_PRESENT ? 6'h00 :
                 r_fmt == 3'b000 ? 6'(r_digit) :
                 r_fmt == 3'b100 ? (r_digit[0] ? 6'h25 : 6'h30) :
                 r_fmt == 3'b010 ? 6'h22 :
                 r_fmt == 3'b011 ? 6'h23 :
                 r_fmt == 3'b110 ? 6'h24 : 6'h00;
  end
endmodule
